universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//  Parametrised successor of the 6-bit right shift register. Supports hold,
//  logical shift left/right, rotate left/right and arithmetic shift right.
//  Shifts either one step per request or as a counted burst with busy/done
//  handshake. Used as the lab's general data-path shifter / serial converter.
// PARAMETERS
//  WIDTH        6   register width in bits (>=2)
//  COUNT_WIDTH  4   width of burst shift count (max burst 2**COUNT_WIDTH-1)
// PORTS
//  clockpulse      in   1            single clock, rising edge
//  clear           in   1            async active-high reset
//  mode            in   3            000 hold, 001 SHR, 010 SHL, 011 ROR, 100 ROL, 101 ASR, 11x hold
//  serialInputMsb  in   1            bit entering MSB on SHR
//  serialInputLsb  in   1            bit entering LSB on SHL
//  enablePreset    in   1            synchronous parallel load of preset
//  preset          in   WIDTH        parallel load value
//  step            in   1            apply mode once (IDLE only)
//  start           in   1            begin counted burst (IDLE only)
//  shiftCount      in   COUNT_WIDTH  burst length, sampled with start
//  out             out  WIDTH        register contents
//  notout          out  WIDTH        ~out, always
//  serialOutMsb    out  1            out[WIDTH-1]
//  serialOutLsb    out  1            out[0]
//  busy            out  1            burst in progress
//  done            out  1            one-cycle pulse, burst finished
// BEHAVIOUR
//  - clear=1 (async, any state): out=0, notout=all 1s, busy=0, done=0, state IDLE,
//    counter=0, latched mode=000. Held while clear=1.
//  - Ops (per edge): SHR {serialInputMsb,out[W-1:1]}; SHL {out[W-2:0],serialInputLsb};
//    ROR {out[0],out[W-1:1]}; ROL {out[W-2:0],out[W-1]}; ASR {out[W-1],out[W-1:1]}.
//  - Priority per edge: enablePreset > start > step. done is 0 unless set below.
//  - enablePreset: out<=preset next edge, in any state; aborts a burst -> IDLE,
//    busy<=0, no done pulse.
//  - FSM IDLE/BUSY.
//    IDLE: step=1 -> apply mode once (1-cycle latency). start=1 with shiftCount=N:
//      latch mode and N; N>0 -> BUSY, busy=1 from next cycle; N=0 -> stay IDLE,
//      no shift, done=1 for one cycle.
//    BUSY: apply latched mode every edge, decrement counter; the edge that does
//      the Nth shift sets busy=0, done=1, state IDLE. Exactly N shifts.
//      Busy high N cycles, done 1 cycle.
//    start/step/mode changes during BUSY are ignored (mode latched at start).
//  - Burst from start edge k: shifts on edges k+1..k+N; done high after edge
//    k+N. A start in the done cycle is accepted (back-to-back bursts).
//  - Hold modes (000,110,111) in a burst still count down; out unchanged.
//  - notout/serialOut* are combinational from out; no extra latency.
// TESTING (WIDTH=6, COUNT_WIDTH=4)
//  - clear pulse then enablePreset, preset=110000 -> out=110000, notout=001111.
//  - mode=001, serialInputMsb=0, 5 step pulses from 110000
//    -> 011000,001100,000110,000011,000001.
//  - preset 100001, mode=011, start with shiftCount=3 -> busy 3 cycles,
//    out=001100, done 1 cycle at busy fall; then mode=100, N=3 -> 100001.
//  - preset 100100, mode=101, start N=2 -> out=111001; start N=0 -> done next
//    cycle, busy never high, out unchanged.
//  - Burst N=8 SHL; enablePreset 101010 on cycle 3 -> out=101010, busy=0, no done;
//    separately assert clear mid-burst -> out=0, busy=0 without clock edge.
//  - During BUSY toggle mode/step/start -> ignored; exactly N shifts of latched mode.

Source files
------------

// File: rtl/universal_shift_register.sv
// universal_shift_register: parametrised shifter with single-step and counted-burst modes
module universal_shift_register #(
  parameter int WIDTH       = 6,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clockpulse,
  input  logic                   clear,
  input  logic [2:0]             mode,
  input  logic                   serialInputMsb,
  input  logic                   serialInputLsb,
  input  logic                   enablePreset,
  input  logic [WIDTH-1:0]       preset,
  input  logic                   step,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] shiftCount,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       notout,
  output logic                   serialOutMsb,
  output logic                   serialOutLsb,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                 state_q;
  logic [WIDTH-1:0]       out_q, step_d, burst_d;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [2:0]             mode_q;
  logic                   busy_q, done_q;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                                input logic msb_in, input logic lsb_in);
    return m == 3'b001 ? {msb_in, v[WIDTH-1:1]} :
           m == 3'b010 ? {v[WIDTH-2:0], lsb_in} :
           m == 3'b011 ? {v[0], v[WIDTH-1:1]} :
           m == 3'b100 ? {v[WIDTH-2:0], v[WIDTH-1]} :
           m == 3'b101 ? {v[WIDTH-1], v[WIDTH-1:1]} : v;
  endfunction

  // single-step uses the live mode, bursts use the mode captured at start
  always_comb begin
    step_d  = apply_op(mode, out_q, serialInputMsb, serialInputLsb);
    burst_d = apply_op(mode_q, out_q, serialInputMsb, serialInputLsb);
  end

  // IDLE/BUSY control with preset overriding everything, including a running burst
  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (enablePreset) begin
        out_q   <= preset;
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == IDLE) begin
        if (start) begin
          mode_q <= mode;
          cnt_q  <= shiftCount;
          if (shiftCount == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q <= BUSY;
            busy_q  <= 1'b1;
          end
        end else if (step) begin
          out_q <= step_d;
        end
      end else begin
        out_q <= burst_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == COUNT_WIDTH'(1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign out          = out_q;
  assign notout       = ~out_q;
  assign serialOutMsb = out_q[WIDTH-1];
  assign serialOutLsb = out_q[0];
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: scoreboard bench with a behavioural reference model
module tb_universal_shift_register;
  localparam int W  = 6;
  localparam int CW = 4;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic [2:0]    mode = '0;
  logic          sin_msb = 1'b0, sin_lsb = 1'b0;
  logic          en_preset = 1'b0;
  logic [W-1:0]  preset = '0;
  logic          step = 1'b0, start = 1'b0;
  logic [CW-1:0] shift_count = '0;
  logic [W-1:0]  out, notout;
  logic          sout_msb, sout_lsb, busy, done;

  universal_shift_register #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clockpulse(clk), .clear(clear), .mode(mode),
    .serialInputMsb(sin_msb), .serialInputLsb(sin_lsb),
    .enablePreset(en_preset), .preset(preset), .step(step), .start(start),
    .shiftCount(shift_count), .out(out), .notout(notout),
    .serialOutMsb(sout_msb), .serialOutLsb(sout_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {int o; bit b; bit d;} exp_t;
  exp_t sbq[$];

  int m_out, m_rem, m_mode;
  bit m_busy, m_done;

  function automatic int op(int m, int v, bit mi, bit li);
    case (m)
      1: return (v >> 1) + (mi ? (1 << (W-1)) : 0);
      2: return ((v * 2) & MASK) + (li ? 1 : 0);
      3: return (v >> 1) + ((v % 2) << (W-1));
      4: return ((v * 2) & MASK) + (v >> (W-1));
      5: return (v >> 1) + (v & (1 << (W-1)));
      default: return v;
    endcase
  endfunction

  task automatic m_reset();
    m_out = 0; m_rem = 0; m_mode = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock edge: advance the model with the inputs seen at this edge and queue the result
  task automatic tick();
    @(posedge clk);
    m_done = 0;
    if (clear) m_reset();
    else if (en_preset) begin m_out = int'(preset); m_busy = 0; m_rem = 0; end
    else if (!m_busy) begin
      if (start) begin
        m_mode = int'(mode);
        if (shift_count == 0) m_done = 1;
        else begin m_busy = 1; m_rem = int'(shift_count); end
      end else if (step) m_out = op(int'(mode), m_out, sin_msb, sin_lsb);
    end else begin
      m_out = op(m_mode, m_out, sin_msb, sin_lsb);
      m_rem--;
      if (m_rem == 0) begin m_busy = 0; m_done = 1; end
    end
    sbq.push_back('{m_out, m_busy, m_done});
    @(negedge clk);
    #1;
  endtask

  // monitor: the register presents a new value every cycle; compare it away from the edge
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      vectors++;
      if (int'(out) != e.o || busy != e.b || done != e.d || notout != ~out ||
          sout_msb != out[W-1] || sout_lsb != out[0]) begin
        miscompares++;
        $display("FAIL scoreboard: out=%b notout=%b smsb=%b slsb=%b busy=%b done=%b expected out=%b busy=%b done=%b at %0t",
                 out, notout, sout_msb, sout_lsb, busy, done, W'(e.o), e.b, e.d, $time);
      end
    end
  end

  task automatic do_start(input logic [2:0] m, input int n);
    mode = m; shift_count = CW'(n); start = 1; tick(); start = 0;
  endtask

  task automatic do_preset(input logic [W-1:0] v);
    preset = v; en_preset = 1; tick(); en_preset = 0;
  endtask

  initial begin
    logic [W-1:0] shr_exp [5] = '{6'b011000, 6'b001100, 6'b000110, 6'b000011, 6'b000001};
    m_reset();
    tick();
    chk("reset_out", int'(out), 0);
    chk("reset_notout", int'(notout), MASK);
    clear = 0;
    tick();
    do_preset(6'b110000);
    chk("preset_out", int'(out), 'b110000);
    chk("preset_notout", int'(notout), 'b001111);
    mode = 3'b001; sin_msb = 0; step = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("shr_step", int'(out), int'(shr_exp[i]));
    end
    step = 0;
    do_preset(6'b100001);
    do_start(3'b011, 3);
    chk("ror_busy_rise", int'(busy), 1);
    for (int i = 0; i < 3; i++) tick();
    chk("ror_out", int'(out), 'b001100);
    chk("ror_done", int'({busy, done}), 'b01);
    do_start(3'b100, 3);
    for (int i = 0; i < 3; i++) tick();
    chk("rol_out", int'(out), 'b100001);
    do_preset(6'b100100);
    do_start(3'b101, 2);
    tick(); tick();
    chk("asr_out", int'(out), 'b111001);
    do_start(3'b001, 0);
    chk("n0_done", int'({busy, done}), 'b01);
    chk("n0_out", int'(out), 'b111001);
    tick();
    chk("n0_done_fall", int'(done), 0);
    do_preset(6'b000011);
    do_start(3'b010, 8);
    tick(); tick();
    do_preset(6'b101010);
    chk("abort_out", int'(out), 'b101010);
    chk("abort_flags", int'({busy, done}), 0);
    tick();
    chk("abort_no_done", int'(done), 0);
    do_start(3'b010, 8);
    tick();
    clear = 1;
    #2;
    chk("async_clear_out", int'(out), 0);
    chk("async_clear_busy", int'(busy), 0);
    m_reset();
    tick();
    clear = 0;
    do_preset(6'b110101);
    do_start(3'b011, 5);
    for (int i = 0; i < 5; i++) begin
      mode = 3'($urandom_range(7)); step = 1'($urandom); start = 1'($urandom);
      shift_count = CW'($urandom);
      tick();
    end
    start = 0; step = 0;
    tick();
    for (int i = 0; i < 600; i++) begin
      clear       = ($urandom_range(99) == 0);
      en_preset   = ($urandom_range(15) == 0);
      preset      = W'($urandom);
      start       = ($urandom_range(5) == 0);
      step        = 1'($urandom);
      mode        = 3'($urandom_range(7));
      shift_count = CW'($urandom);
      sin_msb     = 1'($urandom);
      sin_lsb     = 1'($urandom);
      tick();
    end
    clear = 0;
    tick();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
